// File: rtl/s2p_sync_rx_pkg.sv
// Shared constants and types for the 4-lane bit-serial receiver.
package s2p_sync_rx_pkg;

  localparam int         NUM_LANES  = 4;
  localparam logic [7:0] COM_SYMBOL = 8'hBC;
  // Consecutive aligned all-lane COM bytes needed to declare lock (2..15).
  localparam int         LOCK_COUNT = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

endpackage

// File: rtl/s2p_sync_rx_if.sv
// Serial input lanes and aligned parallel output word of the receiver.
interface s2p_sync_rx_if;
  import s2p_sync_rx_pkg::*;

  logic                 IN_ENB_rx;
  logic [NUM_LANES-1:0] IN_LANE_rx;
  byte_t                OUT_LANE3_rx;
  byte_t                OUT_LANE2_rx;
  byte_t                OUT_LANE1_rx;
  byte_t                OUT_LANE0_rx;
  logic                 OUT_VALID_rx;
  logic                 OUT_SYNC_rx;

  // Drives the serial side and observes the word side.
  modport master (
    output IN_ENB_rx, IN_LANE_rx,
    input  OUT_LANE3_rx, OUT_LANE2_rx, OUT_LANE1_rx, OUT_LANE0_rx,
    input  OUT_VALID_rx, OUT_SYNC_rx
  );

  // The receiver itself.
  modport slave (
    input  IN_ENB_rx, IN_LANE_rx,
    output OUT_LANE3_rx, OUT_LANE2_rx, OUT_LANE1_rx, OUT_LANE0_rx,
    output OUT_VALID_rx, OUT_SYNC_rx
  );

endinterface

// File: rtl/s2p_lane_shift.sv
// One lane's MSB-first deserialiser. next_byte_o is the byte that would be
// held after the current edge, so alignment can be judged on the same edge
// that samples the last bit.
module s2p_lane_shift
  import s2p_sync_rx_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  enb_i,
  input  logic  bit_i,
  output byte_t next_byte_o
);

  byte_t sr_q;

  assign next_byte_o = {sr_q[6:0], bit_i};

  // Shift one bit per enabled clock; hold while disabled.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) begin
      sr_q <= '0;
    end else if (enb_i) begin
      sr_q <= next_byte_o;
    end
  end

endmodule

// File: rtl/s2p_sync_rx.sv
// 4-lane bit-serial receiver: deserialises each lane, aligns to the COM idle
// symbol and presents aligned 4-byte words with a one-cycle valid pulse.
module s2p_sync_rx
  import s2p_sync_rx_pkg::*;
(
  input  logic          IN_CLK_rx,
  input  logic          IN_RESET_rx,
  s2p_sync_rx_if.slave  bus
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  byte_t                       next_byte [NUM_LANES];
  logic                        all_com;
  state_e                      state_q, state_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [3:0]                  com_cnt_q, com_cnt_d;
  logic [NUM_LANES-1:0][7:0]   lane_q, lane_d;
  logic                        valid_q, valid_d;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    s2p_lane_shift u_lane (
      .clk_i       (IN_CLK_rx),
      .rst_i       (IN_RESET_rx),
      .enb_i       (bus.IN_ENB_rx),
      .bit_i       (bus.IN_LANE_rx[g]),
      .next_byte_o (next_byte[g])
    );
  end

  // COM must be present on every lane at once to count as alignment.
  always_comb begin
    all_com = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (next_byte[i] != COM_SYMBOL) all_com = 1'b0;
    end
  end

  // Alignment FSM, byte-phase counter and output word capture.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    lane_d    = lane_q;
    valid_d   = 1'b0;

    if (bus.IN_ENB_rx) begin
      case (state_q)
        SEARCH: begin
          // Sliding compare: any bit position may be the byte boundary.
          if (all_com) begin
            bit_cnt_d = '0;
            com_cnt_d = 4'd1;
            state_d   = LOCKING;
          end
        end

        LOCKING: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (all_com) begin
              com_cnt_d = com_cnt_q + 4'd1;
              if (com_cnt_d == LOCK_CNT) state_d = ACTIVE;
            end else begin
              com_cnt_d = '0;
              state_d   = SEARCH;
            end
          end
        end

        ACTIVE: begin
          // Idle COM bytes leave the word untouched; anything else is data.
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7 && !all_com) begin
            for (int i = 0; i < NUM_LANES; i++) lane_d[i] = next_byte[i];
            valid_d = 1'b1;
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  // State and output registers; reset wins over enable.
  always_ff @(posedge IN_CLK_rx) begin
    if (IN_RESET_rx) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.OUT_LANE3_rx = lane_q[3];
  assign bus.OUT_LANE2_rx = lane_q[2];
  assign bus.OUT_LANE1_rx = lane_q[1];
  assign bus.OUT_LANE0_rx = lane_q[0];
  assign bus.OUT_VALID_rx = valid_q;
  assign bus.OUT_SYNC_rx  = (state_q == ACTIVE);

endmodule

// File: tb/tb_s2p_sync_rx.sv
// Bench for s2p_sync_rx: directed table, hand-written corner sequences and
// randomized traffic compared every cycle against a reference model.
`timescale 1ns/1ps
module tb_s2p_sync_rx;
  import s2p_sync_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #250 clk = ~clk;   // 2 MHz bit clock

  s2p_sync_rx_if bus ();

  s2p_sync_rx dut (
    .IN_CLK_rx   (clk),
    .IN_RESET_rx (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes are judged on a window of the last 8 bits per lane; once a COM is
  // found, byte boundaries are every 8th enabled bit counted from that point.
  int          m_t, m_anchor, m_phase, m_coms;   // phase 0 hunt, 1 confirm, 2 locked
  logic [7:0]  m_win [NUM_LANES];
  logic [31:0] m_word;
  logic        m_valid;

  task automatic model_update(input logic r, input logic e, input logic [3:0] lanes);
    logic allc;
    logic boundary;
    m_valid = 1'b0;
    if (r) begin
      m_t = 0; m_anchor = 0; m_phase = 0; m_coms = 0; m_word = '0;
      for (int i = 0; i < NUM_LANES; i++) m_win[i] = 8'h00;
      return;
    end
    if (!e) return;
    m_t++;
    allc = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      m_win[i] = 8'((int'(m_win[i]) * 2 + int'(lanes[i])) % 256);
      if (m_win[i] != COM_SYMBOL) allc = 1'b0;
    end
    boundary = ((m_t - m_anchor) % 8) == 0;
    if (m_phase == 0) begin
      if (allc) begin m_anchor = m_t; m_coms = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (boundary) begin
        if (allc) begin
          m_coms++;
          if (m_coms == LOCK_COUNT) m_phase = 2;
        end else begin
          m_coms = 0; m_phase = 0;
        end
      end
    end else if (boundary && !allc) begin
      m_word  = {m_win[3], m_win[2], m_win[1], m_win[0]};
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [31:0] dut_word();
    return {bus.OUT_LANE3_rx, bus.OUT_LANE2_rx, bus.OUT_LANE1_rx, bus.OUT_LANE0_rx};
  endfunction

  // One clock: drive, clock, update model, compare shortly after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] lanes);
    rst = r;
    bus.IN_ENB_rx  = e;
    bus.IN_LANE_rx = lanes;
    @(posedge clk);
    model_update(r, e, lanes);
    #1;
    check("model", {30'd0, bus.OUT_SYNC_rx, bus.OUT_VALID_rx, dut_word()},
                   {30'd0, (m_phase == 2) ? 1'b1 : 1'b0, m_valid, m_word});
  endtask

  // Send one byte per lane (word[8i+7:8i] on lane i), MSB first.
  // vcount counts valid pulses; vlate counts pulses not on the last bit.
  task automatic send_byte(input logic [31:0] word, inout int vcount, inout int vlate);
    logic [3:0] lanes;
    for (int b = 7; b >= 0; b--) begin
      for (int i = 0; i < NUM_LANES; i++) lanes[i] = word[8*i + b];
      step(1'b0, 1'b1, lanes);
      if (bus.OUT_VALID_rx) begin
        vcount++;
        if (b != 0) vlate++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          reps;
    logic        exp_sync;
    logic [31:0] exp_word;
    int          exp_valids;
  } vec_t;

  localparam logic [31:0] COM4 = {4{COM_SYMBOL}};

  vec_t vecs [8];

  initial begin
    int vc, vl, sync_at;
    logic [7:0]  com;
    logic [31:0] w;
    logic [3:0]  lanes;

    vecs[0] = '{COM4,         1, 1'b1, 32'h0000_0000, 0};  // 5th COM: idle
    vecs[1] = '{32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF, 1};
    vecs[2] = '{COM4,         2, 1'b1, 32'hDEADBEEF, 0};  // outputs hold
    vecs[3] = '{32'h12345678, 1, 1'b1, 32'h12345678, 1};
    vecs[4] = '{32'hA55AC33C, 1, 1'b1, 32'hA55AC33C, 1};  // back to back
    vecs[5] = '{32'hBCBCBC00, 1, 1'b1, 32'hBCBCBC00, 1};  // mixed lanes = data
    vecs[6] = '{32'h0000_0000, 1, 1'b1, 32'h0000_0000, 1};
    vecs[7] = '{COM4,         1, 1'b1, 32'h0000_0000, 0};

    com = COM_SYMBOL;
    bus.IN_ENB_rx  = 1'b1;
    bus.IN_LANE_rx = '0;

    // Reset for 3 cycles, then 40 idle-zero cycles.
    repeat (3) step(1'b1, 1'b1, 4'h0);
    check("reset_out", {30'd0, bus.OUT_SYNC_rx, bus.OUT_VALID_rx, dut_word()}, 64'd0);
    vc = 0;
    repeat (40) begin
      step(1'b0, 1'b1, 4'h0);
      if (bus.OUT_VALID_rx || bus.OUT_SYNC_rx) vc++;
    end
    check("zero_stream_quiet", 64'(vc), 64'd0);

    // Bit offset 3, then COMs: lock expected on the 32nd COM bit.
    repeat (3) step(1'b0, 1'b1, 4'h0);
    sync_at = 0;
    vc = 0;
    for (int n = 1; n <= 32; n++) begin
      step(1'b0, 1'b1, {4{com[7 - ((n - 1) % 8)]}});
      if (bus.OUT_SYNC_rx && sync_at == 0) sync_at = n;
      if (bus.OUT_VALID_rx) vc++;
    end
    check("lock_cycle", 64'(sync_at), 64'd32);
    check("lock_no_valid", 64'(vc), 64'd0);

    // Directed table in ACTIVE.
    for (int v = 0; v < 8; v++) begin
      vc = 0; vl = 0;
      for (int r = 0; r < vecs[v].reps; r++) send_byte(vecs[v].word, vc, vl);
      check($sformatf("vec%0d_sync", v),   64'(bus.OUT_SYNC_rx), 64'(vecs[v].exp_sync));
      check($sformatf("vec%0d_word", v),   64'(dut_word()), 64'(vecs[v].exp_word));
      check($sformatf("vec%0d_valids", v), 64'(vc), 64'(vecs[v].exp_valids));
      check($sformatf("vec%0d_timing", v), 64'(vl), 64'd0);
    end

    // Enable dropped for 5 cycles mid-byte, stimulus paused.
    w = 32'hCAFEF00D;
    vc = 0;
    for (int b = 7; b >= 4; b--) begin
      for (int i = 0; i < NUM_LANES; i++) lanes[i] = w[8*i + b];
      step(1'b0, 1'b1, lanes);
    end
    repeat (5) begin
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      if (bus.OUT_VALID_rx) vc++;
    end
    check("enb_low_no_valid", 64'(vc), 64'd0);
    check("enb_low_hold", 64'(dut_word()), 64'h0);
    for (int b = 3; b >= 0; b--) begin
      for (int i = 0; i < NUM_LANES; i++) lanes[i] = w[8*i + b];
      step(1'b0, 1'b1, lanes);
      if (bus.OUT_VALID_rx) vc++;
    end
    check("enb_resume_valid", 64'(vc), 64'd1);
    check("enb_resume_word", 64'(dut_word()), 64'hCAFEF00D);

    // Reset mid-byte in ACTIVE, then data without COMs.
    w = 32'h11223344;
    for (int b = 7; b >= 5; b--) begin
      for (int i = 0; i < NUM_LANES; i++) lanes[i] = w[8*i + b];
      step(1'b0, 1'b1, lanes);
    end
    step(1'b1, 1'b1, 4'hF);
    check("midreset_out", {30'd0, bus.OUT_SYNC_rx, bus.OUT_VALID_rx, dut_word()}, 64'd0);
    vc = 0; vl = 0;
    send_byte(32'h11223344, vc, vl);
    send_byte(32'h55667788, vc, vl);
    send_byte(32'h99AABBCC, vc, vl);
    check("nocom_no_valid", 64'(vc), 64'd0);
    check("nocom_no_sync", 64'(bus.OUT_SYNC_rx), 64'd0);

    // LOCKING aborted by 0x55 after 2 COMs: 4 fresh COMs needed afterwards.
    vc = 0; vl = 0;
    send_byte(COM4, vc, vl);
    send_byte(COM4, vc, vl);
    send_byte(32'h55555555, vc, vl);
    send_byte(COM4, vc, vl);
    send_byte(COM4, vc, vl);
    send_byte(COM4, vc, vl);
    check("abort_3com_no_sync", 64'(bus.OUT_SYNC_rx), 64'd0);
    send_byte(COM4, vc, vl);
    check("abort_4com_sync", 64'(bus.OUT_SYNC_rx), 64'd1);
    check("abort_no_valid", 64'(vc), 64'd0);

    // Randomized traffic with enable gaps and occasional mid-stream reset.
    for (int round = 0; round < 8; round++) begin
      int rst_at;
      step(1'b1, 1'b1, 4'h0);
      repeat ($urandom_range(0, 7)) step(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      rst_at = (round % 3 == 2) ? int'($urandom_range(0, 29)) : -1;
      for (int k = 0; k < 6 + 30; k++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (k < 4 + (round % 3)) w = COM4;
        else if (sel < 3) w = COM4;
        else if (sel == 3) w = {COM_SYMBOL, COM_SYMBOL, 8'($urandom_range(0, 255)), COM_SYMBOL};
        else w = $urandom;
        if (k == rst_at) step(1'b1, 1'b1, 4'h0);
        for (int b = 7; b >= 0; b--) begin
          for (int i = 0; i < NUM_LANES; i++) lanes[i] = w[8*i + b];
          while ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, ~lanes);
          step(1'b0, 1'b1, lanes);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
